mem_rd_ctrl: RTL

MEM_RD_CTRL -- requirements
Module: mem_rd_ctrl

---
 rtl/mem_rd_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/mem_rd_ctrl.sv
// Register-bank read/write controller: one-hot write enables, chip-selects onto a
// shared tri-state read bus, response handshake. Define MEM_RD_PARITY_EN to add rsp_par.
module mem_rd_ctrl #(
  parameter int NrOfBits = 8,
  parameter int AddrBits = 3
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Tick,
  input  logic                     rd_req,
  input  logic                     wr_req,
  input  logic [AddrBits-1:0]      addr,
  input  logic [NrOfBits-1:0]      wr_data,
  output logic                     req_ack,
  output logic [(2**AddrBits)-1:0] reg_ce,
  output logic [(2**AddrBits)-1:0] reg_cs,
  output logic [NrOfBits-1:0]      bus_d,
  input  logic [NrOfBits-1:0]      bus_q,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [NrOfBits-1:0]      rsp_data
`ifdef MEM_RD_PARITY_EN
  ,
  output logic                     rsp_par
`endif
);
  localparam int N = 2**AddrBits;
  localparam logic [N-1:0] ONE = 1;

  typedef enum logic [2:0] {IDLE, WRITE, DRIVE, CAPTURE, RESP} state_t;

  state_t              state;
  logic [AddrBits-1:0] addr_q;
  logic                ack_q;
  logic [N-1:0]        sel;

  assign sel = ONE << addr_q;

  // The ack pulse is only meaningful in an enabled cycle; masking keeps it low
  // while Tick=0 without losing it before the requester can see it.
  assign req_ack = ack_q & Tick;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      ack_q     <= 1'b0;
      reg_ce    <= '0;
      reg_cs    <= '1;
      bus_d     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
`ifdef MEM_RD_PARITY_EN
      rsp_par   <= 1'b0;
`endif
    end else if (Tick) begin
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          reg_ce <= '0;
          reg_cs <= '1;
          if (wr_req) begin
            ack_q  <= 1'b1;
            addr_q <= addr;
            bus_d  <= wr_data;
            state  <= WRITE;
          end else if (rd_req) begin
            ack_q  <= 1'b1;
            addr_q <= addr;
            state  <= DRIVE;
          end
        end
        WRITE: begin
          reg_ce <= sel;
          state  <= IDLE;
        end
        DRIVE: begin
          reg_cs <= ~sel;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          // bus_q has been driven for a full cycle by the selected register
          rsp_data <= bus_q;
`ifdef MEM_RD_PARITY_EN
          rsp_par  <= ^bus_q;
`endif
          state    <= RESP;
        end
        RESP: begin
          reg_cs <= '1;
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
